// File: rtl/imem_boot_loader.sv
// imem_boot_loader: receives a length-prefixed big-endian byte stream and
// writes it into the instruction memory at consecutive word addresses,
// holding the core in reset until a complete program has been loaded.
module imem_boot_loader #(
   parameter int MAX_WORDS = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic        imem_we,
   output logic [31:0] imem_addr,
   output logic [31:0] imem_wdata,
   output logic        cpu_rst_n,
   output logic        busy,
   output logic        done,
   output logic        err
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LEN_HI = 3'd1,
      S_LEN_LO = 3'd2,
      S_DATA   = 3'd3,
      S_WRITE  = 3'd4,
      S_DONE   = 3'd5,
      S_ERR    = 3'd6
   } state_t;

   localparam logic [15:0] MAX_LEN = 16'(MAX_WORDS);

   state_t      state_r;
   state_t      state_nxt_s;
   logic [15:0] len_r;      // program length N in words
   logic [9:0]  k_r;        // index of the word being assembled
   logic [1:0]  cnt_r;      // bytes of the current word received so far
   logic [31:0] asm_r;      // word assembly shift register

   logic        xfer_s;
   logic [15:0] len_full_s;
   logic        last_word_s;

   // Outputs are pure decodes of the registered state and datapath, so no
   // rx_* input can reach an output combinationally.
   assign rx_ready   = (state_r == S_LEN_HI) || (state_r == S_LEN_LO) || (state_r == S_DATA);
   assign imem_we    = (state_r == S_WRITE);
   assign imem_addr  = {22'd0, k_r};
   assign imem_wdata = asm_r;
   assign busy       = rx_ready || (state_r == S_WRITE);
   assign done       = (state_r == S_DONE);
   assign err        = (state_r == S_ERR);
   assign cpu_rst_n  = (state_r == S_DONE);

   assign xfer_s      = rx_valid && rx_ready;
   // Full length as it stands while the low length byte is on the link.
   assign len_full_s  = {len_r[15:8], rx_data};
   // k never exceeds N-1 because N <= MAX_WORDS is checked before DATA.
   assign last_word_s = ({6'd0, k_r} == (len_r - 16'd1));

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state decode: stream framing, length checks and word sequencing.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
               state_nxt_s = S_LEN_HI;
            end else begin
               state_nxt_s = state_r;
            end
         end
         S_LEN_HI: begin
            if (xfer_s) begin
               state_nxt_s = S_LEN_LO;
            end else begin
               state_nxt_s = S_LEN_HI;
            end
         end
         S_LEN_LO: begin
            if (!xfer_s) begin
               state_nxt_s = S_LEN_LO;
            end else if (len_full_s == 16'd0) begin
               state_nxt_s = S_DONE;
            end else if (len_full_s > MAX_LEN) begin
               state_nxt_s = S_ERR;
            end else begin
               state_nxt_s = S_DATA;
            end
         end
         S_DATA: begin
            if (xfer_s && (cnt_r == 2'd3)) begin
               state_nxt_s = S_WRITE;
            end else begin
               state_nxt_s = S_DATA;
            end
         end
         S_WRITE: begin
            if (last_word_s) begin
               state_nxt_s = S_DONE;
            end else begin
               state_nxt_s = S_DATA;
            end
         end
         default: begin
            state_nxt_s = S_IDLE;
         end
      endcase
   end

   // Datapath: length capture, byte assembly and word index advance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         len_r <= 16'd0;
         k_r   <= 10'd0;
         cnt_r <= 2'd0;
         asm_r <= 32'd0;
      end else begin
         case (state_r)
            S_LEN_HI: begin
               if (xfer_s) begin
                  len_r[15:8] <= rx_data;
               end
            end
            S_LEN_LO: begin
               if (xfer_s) begin
                  len_r[7:0] <= rx_data;
                  k_r        <= 10'd0;
                  cnt_r      <= 2'd0;
               end
            end
            S_DATA: begin
               if (xfer_s) begin
                  asm_r <= {asm_r[23:0], rx_data};
                  cnt_r <= cnt_r + 2'd1;
               end
            end
            S_WRITE: begin
               if (!last_word_s) begin
                  k_r   <= k_r + 10'd1;
                  cnt_r <= 2'd0;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: the driver pushes expected memory
// writes derived from the stream format, a monitor pops them on imem_we.
module tb_imem_boot_loader;

   localparam int MAX_WORDS = 1024;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  rx_data = 8'd0;
   logic        rx_valid = 1'b0;
   logic        rx_ready;
   logic        imem_we;
   logic [31:0] imem_addr;
   logic [31:0] imem_wdata;
   logic        cpu_rst_n;
   logic        busy;
   logic        done;
   logic        err;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [41:0] exp_q[$];   // {word index, word}
   logic [31:0] prog_q[$];  // program for the next load

   imem_boot_loader #(.MAX_WORDS(MAX_WORDS)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .cpu_rst_n  (cpu_rst_n),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;

   // Free-running cycle counter for throughput checks.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Monitor: every write strobe must match the oldest expected write.
   always @(negedge clk) begin
      if (rst_n && imem_we) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_write actual addr=%h data=%h expected=no write", imem_addr, imem_wdata);
         end else begin
            logic [41:0] e;
            e = exp_q.pop_front();
            check("write_addr", 72'(imem_addr), 72'({22'd0, e[41:32]}));
            check("write_data", 72'(imem_wdata), 72'(e[31:0]));
         end
      end
   end

   function automatic logic [69:0] outs();
      return {rx_ready, imem_we, busy, done, err, cpu_rst_n, imem_addr, imem_wdata};
   endfunction

   // Present one byte after 'gap' idle cycles; returns just after the transfer edge.
   task automatic send_byte(input logic [7:0] b, input int gap);
      int guard;
      repeat (gap) begin
         @(negedge clk);
         rx_valid = 1'b0;
         rx_data  = 8'($urandom);
      end
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = b;
      start    = ($urandom_range(0, 15) == 0);  // stray start while busy: ignored
      guard = 0;
      while (!rx_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (!rx_ready) begin
         total++;
         bad++;
         $display("FAIL rx_ready_timeout actual=0 expected=1");
      end
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Start pulse, optionally with a byte on the link that must not be consumed.
   task automatic do_start(input bit with_byte);
      @(negedge clk);
      start = 1'b1;
      if (with_byte) begin
         rx_valid = 1'b1;
         rx_data  = 8'hFF;
      end
      @(posedge clk);
      #1;
      start    = 1'b0;
      rx_valid = 1'b0;
      @(negedge clk);
      check("start_busy_ready", {done, cpu_rst_n, busy, rx_ready}, 4'b0011);
   endtask

   // Full load from the reference model: length header, then prog_q words.
   task automatic run_load(input int n, input int max_gap, input bit with_byte);
      int  c0;
      bit  legal;
      logic [15:0] nl;
      logic [31:0] w;
      nl    = 16'(n);
      legal = (n >= 1) && (n <= MAX_WORDS);
      do_start(with_byte);
      send_byte(nl[15:8], $urandom_range(0, max_gap));
      send_byte(nl[7:0], $urandom_range(0, max_gap));
      c0 = cyc;
      if (legal) begin
         for (int i = 0; i < n; i++) begin
            w = prog_q[i];
            exp_q.push_back({10'(i), w});
            send_byte(w[31:24], $urandom_range(0, max_gap));
            send_byte(w[23:16], $urandom_range(0, max_gap));
            send_byte(w[15:8],  $urandom_range(0, max_gap));
            send_byte(w[7:0],   $urandom_range(0, max_gap));
         end
         if (max_gap == 0) check("throughput_cycles", 72'(cyc - c0), 72'(5 * n - 1));
         @(negedge clk);
         check("write_cycle", {imem_we, rx_ready, done, cpu_rst_n}, 4'b1000);
         rx_valid = 1'b0;
         @(negedge clk);
         check("done_entry", {done, cpu_rst_n, busy, rx_ready, err}, 5'b11000);
         check("all_writes_seen", 72'(exp_q.size()), 72'd0);
      end else if (n == 0) begin
         @(negedge clk);
         check("empty_done", {done, cpu_rst_n, busy, rx_ready, imem_we}, 5'b11000);
         rx_valid = 1'b0;
      end else begin
         @(negedge clk);
         check("oversize_err", {err, rx_ready, cpu_rst_n, busy, done, imem_we}, 6'b100000);
         // Link keeps offering bytes; ERR must refuse them all.
         rx_valid = 1'b1;
         repeat (5) begin
            @(negedge clk);
            check("err_refuses", {err, rx_ready, cpu_rst_n}, 3'b100);
         end
         rx_valid = 1'b0;
      end
      prog_q.delete();
   endtask

   task automatic fill_random(input int n);
      prog_q.delete();
      for (int i = 0; i < n; i++) prog_q.push_back($urandom);
   endtask

   initial begin
      // Reset with random inputs: every output must stay zero.
      rst_n = 1'b0;
      repeat (8) begin
         @(negedge clk);
         check("reset_outputs", 72'(outs()), 72'd0);
         start    = 1'($urandom);
         rx_valid = 1'($urandom);
         rx_data  = 8'($urandom);
      end
      @(negedge clk);
      start    = 1'b0;
      rx_valid = 1'b0;
      rst_n    = 1'b1;
      repeat (20) @(negedge clk);
      check("idle_holds", 72'(outs()), 72'd0);

      // Fixed 3-word program, back-to-back, start coincident with a byte.
      prog_q = '{32'h20010002, 32'h00221820, 32'h08000000};
      run_load(3, 0, 1'b1);

      // Empty program and oversize.
      run_load(0, 0, 1'b0);
      run_load(1025, 0, 1'b0);
      run_load(32'h0000_8000, 3, 1'b0);

      // Random programs with and without flow-control gaps.
      for (int r = 0; r < 6; r++) begin
         int n;
         n = $urandom_range(1, 12);
         fill_random(n);
         run_load(n, (r % 2 == 0) ? 7 : 0, 1'($urandom));
      end

      // Largest legal program.
      fill_random(MAX_WORDS);
      run_load(MAX_WORDS, 0, 1'b0);

      // Reset in the middle of a 4-word load, after the first write.
      fill_random(4);
      do_start(1'b0);
      send_byte(8'h00, 0);
      send_byte(8'h04, 0);
      exp_q.push_back({10'd0, prog_q[0]});
      send_byte(prog_q[0][31:24], 0);
      send_byte(prog_q[0][23:16], 0);
      send_byte(prog_q[0][15:8], 0);
      send_byte(prog_q[0][7:0], 0);
      send_byte(prog_q[1][31:24], 0);
      send_byte(prog_q[1][23:16], 2);
      #2;
      rst_n = 1'b0;
      #1;
      check("midload_reset_outputs", 72'(outs()), 72'd0);
      check("midload_first_word_written", 72'(exp_q.size()), 72'd0);
      rx_valid = 1'b0;
      prog_q.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      check("post_reset_idle", {cpu_rst_n, busy, done, err}, 4'b0000);
      fill_random(2);
      run_load(2, 4, 1'b0);

      repeat (5) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Watchdog so the run always ends.
   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/imem_boot_loader.md
# imem_boot_loader

Boot-time controller for the 1024-word instruction memory of the single-cycle core. It receives a program as a byte stream, assembles big-endian 32-bit words, and drives the instruction memory write port at consecutive word addresses. The core is held in reset until the load completes. It sits between the host byte link (UART receiver or testbench) and the instruction memory, and replaces hard-coded `initial` program images.

## Interface
- `MAX_WORDS`, 1024: instruction memory depth in words; largest legal program length.
- `clk` input 1: single system clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: one-cycle load request; honoured only in IDLE, DONE, ERR.
- `rx_data` input 8: stream byte.
- `rx_valid` input 1: `rx_data` valid.
- `rx_ready` output 1: loader accepts byte; transfer when `rx_valid && rx_ready`.
- `imem_we` output 1: one-cycle instruction memory write strobe.
- `imem_addr` output 32: word address, zero-extended word index.
- `imem_wdata` output 32: assembled instruction word.
- `cpu_rst_n` output 1: active-low reset to the core; high only in DONE.
- `busy` output 1: high in LEN_HI, LEN_LO, DATA, WRITE.
- `done` output 1: high in DONE.
- `err` output 1: high in ERR.

## Operation
- Stream format: 2-byte word count N (MSB first), then 4·N bytes, each word MSB first (`byte0` → `[31:24]`).
- States: IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE, ERR.
- IDLE/DONE/ERR + `start` → LEN_HI; otherwise hold. `start` in busy states is ignored.
- LEN_HI: on transfer, latch `N[15:8]` → LEN_LO.
- LEN_LO: on transfer, latch `N[7:0]`; clear the word index k and byte count. If the full N == 0 → DONE. If N > `MAX_WORDS` → ERR. Otherwise → DATA.
- DATA: each transfer shifts the byte into a 32-bit assembly register (`{asm[23:0], rx_data}`). On the 4th byte → WRITE.
- WRITE: `imem_we`=1, `imem_addr`={22'b0,k}, `imem_wdata`=assembled word. Next state is DONE if k == N−1; otherwise k increments, byte count clears, and the next state is DATA.
- `rx_ready`=1 only in LEN_HI, LEN_LO, DATA. No byte is accepted in WRITE.
- ERR: no memory writes, core held in reset, and further stream bytes are not accepted. Exit only by `start` or `rst_n`.
- `start` in DONE drops `cpu_rst_n` and begins a reload. Earlier memory contents are overwritten word by word.
- Memory is never cleared by this block. Words beyond N keep their previous contents.
- k is 10 bits wide and never wraps, because N ≤ `MAX_WORDS` is enforced.

## Timing
- All outputs are registered or decoded from the registered state. No combinational path from `rx_*` to outputs.
- Reset values: state IDLE, `rx_ready`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `cpu_rst_n`=0, `busy`=0, `done`=0, `err`=0.
- 4th data byte accepted at edge t: `imem_we` is high for exactly the cycle after t. `rx_ready` is low during that cycle and returns high the following cycle, unless the state is DONE.
- Throughput: 5 cycles per word minimum with back-to-back `rx_valid`. `rx_valid` gaps stall without losing the partial word.
- `cpu_rst_n` rises in the cycle after the final WRITE cycle, i.e. on DONE entry. For N=0 it rises in the cycle after the LEN_LO transfer.
- `start` accepted at edge t: `busy`=1 and `rx_ready`=1 from t+1. `cpu_rst_n` and `done` are low from t+1.
- `rst_n` low mid-load: all state clears immediately (asynchronous). A partially written program remains in memory. The core stays in reset until a subsequent successful load.
- Simultaneous `start` and `rx_valid` in IDLE: the byte is not consumed, because `rx_ready`=0 in IDLE.

## Test plan
- Reset: hold `rst_n`=0 with random inputs. All outputs are 0. After release with no `start`, IDLE holds and `cpu_rst_n` stays 0 indefinitely.
- 3-word load, back-to-back bytes: stream 00 03, 20 01 00 02, 00 22 18 20, 08 00 00 00. Expect exactly 3 write pulses: addr 0 = 0x20010002, addr 1 = 0x00221820, addr 2 = 0x08000000. Then `done`=1 and `cpu_rst_n`=1 one cycle after the last pulse.
- Empty program: stream 00 00. Expect no `imem_we`; `done` and `cpu_rst_n` go high the cycle after the second byte.
- Oversize: stream 04 01 (N=1025). Expect ERR, `err`=1, `rx_ready`=0, no `imem_we`, `cpu_rst_n`=0. A later `start` plus a valid stream succeeds.
- Flow control: apply random 0–7 cycle gaps on `rx_valid`, and hold `rx_valid`=1 during WRITE. The data written is identical to the back-to-back case, and no byte is dropped or duplicated.
- Reset mid-load: assert `rst_n` low after word 1 of N=4. Outputs return to reset values. Reload with N=2 from `start` writes addrs 0–1 correctly and releases the core.
